// File: rtl/mc_timed_request_queue_pkg.sv
// Shared types and DDR5 address-field layout for the timed request queue.
// The layout is fixed across address widths; only the row field grows with ADDR_W.
package mc_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2
  } mc_op_e;

  // LSB position / width of each decoded address field.
  localparam int BYTE_LSB = 0;
  localparam int BYTE_W   = 2;
  localparam int COLL_LSB = 2;
  localparam int COLL_W   = 4;
  localparam int CHAN_LSB = 6;
  localparam int CHAN_W   = 1;
  localparam int BG_LSB   = 7;
  localparam int BG_W     = 3;
  localparam int BANK_LSB = 10;
  localparam int BANK_W   = 2;
  localparam int COLH_LSB = 12;
  localparam int COLH_W   = 6;
  localparam int ROW_LSB  = 18;
  localparam int COL_W    = COLH_W + COLL_W;

endpackage

// File: rtl/mc_timed_request_queue_if.sv
// Front-end / scheduler bundle for mc_timed_request_queue; the queue takes the slave side.
interface mc_timed_request_queue_if
  import mc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CORE_W = 4,
  parameter int TIME_W = 64,
  parameter int ADDR_W = 34
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ROW_W = ADDR_W - ROW_LSB;

  // Both channels: a beat transfers on a clock edge where valid && ready; the
  // source keeps valid and its data stable until that edge, ready may toggle freely.
  logic              in_valid;
  logic              in_ready;
  logic [CORE_W-1:0] in_core;
  logic [TIME_W-1:0] in_time;
  logic [1:0]        in_op;
  logic [ADDR_W-1:0] in_addr;

  logic              out_valid;
  logic              out_ready;
  logic [CORE_W-1:0] out_core;
  logic [1:0]        out_op;
  logic [TIME_W-1:0] out_time;
  logic [BYTE_W-1:0] out_byte;
  logic [COL_W-1:0]  out_column;
  logic              out_channel;
  logic [BG_W-1:0]   out_bank_group;
  logic [BANK_W-1:0] out_bank;
  logic [ROW_W-1:0]  out_row;
  logic              out_late;

  logic [TIME_W-1:0] cpu_cycle;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output in_valid, in_core, in_time, in_op, in_addr, out_ready,
    input  in_ready, out_valid, out_core, out_op, out_time, out_byte, out_column,
           out_channel, out_bank_group, out_bank, out_row, out_late,
           cpu_cycle, count, full, empty
  );

  modport slave (
    input  in_valid, in_core, in_time, in_op, in_addr, out_ready,
    output in_ready, out_valid, out_core, out_op, out_time, out_byte, out_column,
           out_channel, out_bank_group, out_bank, out_row, out_late,
           cpu_cycle, count, full, empty
  );

endinterface

// File: rtl/mc_timed_request_queue_addr_decode.sv
// Combinational split of a physical address into DDR5 byte/column/channel/bank-group/bank/row.
module mc_addr_decode
  import mc_pkg::*;
#(
  parameter int ADDR_W = 34
) (
  input  logic [ADDR_W-1:0]         addr_i,
  output logic [BYTE_W-1:0]         byte_o,
  output logic [COL_W-1:0]          column_o,
  output logic [CHAN_W-1:0]         channel_o,
  output logic [BG_W-1:0]           bank_group_o,
  output logic [BANK_W-1:0]         bank_o,
  output logic [ADDR_W-ROW_LSB-1:0] row_o
);

  assign byte_o       = addr_i[BYTE_LSB +: BYTE_W];
  // Column is split around the channel/bank bits: high part sits above the bank field.
  assign column_o     = {addr_i[COLH_LSB +: COLH_W], addr_i[COLL_LSB +: COLL_W]};
  assign channel_o    = addr_i[CHAN_LSB +: CHAN_W];
  assign bank_group_o = addr_i[BG_LSB +: BG_W];
  assign bank_o       = addr_i[BANK_LSB +: BANK_W];
  assign row_o        = addr_i[ADDR_W-1:ROW_LSB];

endmodule

// File: rtl/mc_timed_request_queue.sv
// In-order request FIFO that releases its head once the CPU-cycle counter reaches
// the request time, decodes the address and presents it through one output register.
module mc_timed_request_queue
  import mc_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CORE_W    = 4,
  parameter int TIME_W    = 64,
  parameter int ADDR_W    = 34,
  parameter int CLK_RATIO = 2
) (
  input  logic                      dimm_clock,
  input  logic                      reset_n,
  mc_timed_request_queue_if.slave   q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PS_W  = (CLK_RATIO > 1) ? $clog2(CLK_RATIO) : 1;
  localparam int ROW_W = ADDR_W - ROW_LSB;

  // Entry layout depends on the module parameters, so it is declared here.
  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic [TIME_W-1:0] req_time;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
  } req_t;

  typedef struct packed {
    logic              valid;
    logic              late;
    logic [CORE_W-1:0] core;
    logic [1:0]        op;
    logic [TIME_W-1:0] req_time;
    logic [BYTE_W-1:0] byte_f;
    logic [COL_W-1:0]  column;
    logic [CHAN_W-1:0] channel;
    logic [BG_W-1:0]   bank_group;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
  } out_t;

  req_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PS_W-1:0]   pre_q, pre_d;
  logic [TIME_W-1:0] cyc_q, cyc_d;
  out_t              out_q, out_d;

  req_t              in_req;
  req_t              head;
  logic              full, empty, eligible, load, push, pop;

  logic [BYTE_W-1:0] dec_byte;
  logic [COL_W-1:0]  dec_column;
  logic [CHAN_W-1:0] dec_channel;
  logic [BG_W-1:0]   dec_bank_group;
  logic [BANK_W-1:0] dec_bank;
  logic [ROW_W-1:0]  dec_row;

  assign in_req   = '{core: q.in_core, req_time: q.in_time, op: q.in_op, addr: q.in_addr};
  assign head     = mem_q[rd_ptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  // >= so a request whose time already passed is still released.
  assign eligible = !empty && (cyc_q >= head.req_time);
  assign load     = !out_q.valid || q.out_ready;
  assign push     = q.in_valid && !full;
  assign pop      = load && eligible;

  mc_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr_i       (head.addr),
    .byte_o       (dec_byte),
    .column_o     (dec_column),
    .channel_o    (dec_channel),
    .bank_group_o (dec_bank_group),
    .bank_o       (dec_bank),
    .row_o        (dec_row)
  );

  always_comb begin
    pre_d    = pre_q + 1'b1;
    cyc_d    = cyc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    out_d    = out_q;

    if (pre_q == PS_W'(CLK_RATIO - 1)) begin
      pre_d = '0;
      cyc_d = cyc_q + 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (load) begin
      out_d.valid = eligible;
      if (eligible) begin
        out_d.late       = (cyc_q > head.req_time);
        out_d.core       = head.core;
        out_d.op         = head.op;
        out_d.req_time   = head.req_time;
        out_d.byte_f     = dec_byte;
        out_d.column     = dec_column;
        out_d.channel    = dec_channel;
        out_d.bank_group = dec_bank_group;
        out_d.bank       = dec_bank;
        out_d.row        = dec_row;
      end
    end
  end

  always_ff @(posedge dimm_clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pre_q    <= '0;
      cyc_q    <= '0;
      out_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      cyc_q    <= cyc_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge dimm_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_req;
    end
  end

  assign q.in_ready       = !full;
  assign q.out_valid      = out_q.valid;
  assign q.out_late       = out_q.late;
  assign q.out_core       = out_q.core;
  assign q.out_op         = out_q.op;
  assign q.out_time       = out_q.req_time;
  assign q.out_byte       = out_q.byte_f;
  assign q.out_column     = out_q.column;
  assign q.out_channel    = out_q.channel;
  assign q.out_bank_group = out_q.bank_group;
  assign q.out_bank       = out_q.bank;
  assign q.out_row        = out_q.row;
  assign q.cpu_cycle      = cyc_q;
  assign q.count          = count_q;
  assign q.full           = full;
  assign q.empty          = empty;

endmodule

// File: tb/tb_mc_timed_request_queue.sv
// Directed bench for mc_timed_request_queue: a DEPTH=16 instance for most scenarios
// and a DEPTH=4 instance for pointer wrap while streaming.
`timescale 1ns/1ps
module tb_mc_timed_request_queue;
  import mc_pkg::*;

  localparam int ROW_W = 16;

  logic dimm_clock = 1'b0;
  logic reset_n    = 1'b0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  logic [ROW_W-1:0] exp_q[$];

  always #5 dimm_clock = ~dimm_clock;

  mc_timed_request_queue_if #(.DEPTH(16)) bus ();
  mc_timed_request_queue_if #(.DEPTH(4))  bus4 ();

  mc_timed_request_queue #(.DEPTH(16), .CLK_RATIO(2)) dut (
    .dimm_clock (dimm_clock),
    .reset_n    (reset_n),
    .q          (bus)
  );

  mc_timed_request_queue #(.DEPTH(4), .CLK_RATIO(2)) dut4 (
    .dimm_clock (dimm_clock),
    .reset_n    (reset_n),
    .q          (bus4)
  );

  // ---------------- clock / reset helpers ----------------
  task automatic step();
    @(posedge dimm_clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0; bus.in_core  = '0; bus.in_time  = '0; bus.in_op  = '0; bus.in_addr  = '0; bus.out_ready  = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_core = '0; bus4.in_time = '0; bus4.in_op = '0; bus4.in_addr = '0; bus4.out_ready = 1'b0;
  endtask

  // Leaves the bench 1ns after a posedge with reset released: the next edge is edge 1.
  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] core, input logic [63:0] t, input logic [1:0] op, input logic [33:0] addr);
    bus.in_valid = 1'b1;
    bus.in_core  = core;
    bus.in_time  = t;
    bus.in_op    = op;
    bus.in_addr  = addr;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    n_checks++; if (bus.cpu_cycle !== 64'd0) begin n_fail++; $display("FAIL reset_cpu_cycle: got %0d expected 0", bus.cpu_cycle); end
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_late !== 1'b0) begin n_fail++; $display("FAIL reset_out_late: got %0b expected 0", bus.out_late); end
    n_checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%0b full=%0b expected empty=1 full=0", bus.empty, bus.full); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    n_checks++; if (bus.out_row !== 16'd0 || bus.out_time !== 64'd0 || bus.out_column !== 10'd0) begin n_fail++; $display("FAIL reset_out_data: got row=%0h time=%0h col=%0h expected 0", bus.out_row, bus.out_time, bus.out_column); end

    reset_n = 1'b1;
    drive(4'd1, 64'd1000, OP_READ, 34'h1);
    for (int k = 1; k <= 7; k++) begin
      step();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.cpu_cycle !== 64'(k / 2)) begin n_fail++; $display("FAIL prescale_edge%0d: got %0d expected %0d", k, bus.cpu_cycle, k / 2); end
    end
    n_checks++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 1", bus.count); end

    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.cpu_cycle !== 64'd0) begin n_fail++; $display("FAIL midreset_cpu_cycle: got %0d expected 0", bus.cpu_cycle); end
    n_checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL midreset_count: got %0d empty=%0b expected 0 empty=1", bus.count, bus.empty); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %0b expected 0", bus.out_valid); end
    step();
    step();
    n_checks++; if (bus.cpu_cycle !== 64'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL held_reset: got cyc=%0d valid=%0b expected 0 0", bus.cpu_cycle, bus.out_valid); end
  endtask

  task automatic test_decode();
    do_reset();
    bus.out_ready = 1'b1;
    drive(4'd5, 64'd0, OP_WRITE, 34'h2_DEAD_BEEF);
    step();  // edge 1: push
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.count !== 5'd1) begin n_fail++; $display("FAIL dec_latency1: got valid=%0b count=%0d expected 0 1", bus.out_valid, bus.count); end
    step();  // edge 2: load output
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dec_latency2: got valid=%0b expected 1", bus.out_valid); end
    n_checks++; if (bus.out_byte !== 2'd3) begin n_fail++; $display("FAIL dec_byte: got %0h expected 3", bus.out_byte); end
    n_checks++; if (bus.out_column !== 10'h1BB) begin n_fail++; $display("FAIL dec_column: got %0h expected 1bb", bus.out_column); end
    n_checks++; if (bus.out_channel !== 1'b1) begin n_fail++; $display("FAIL dec_channel: got %0h expected 1", bus.out_channel); end
    n_checks++; if (bus.out_bank_group !== 3'd5) begin n_fail++; $display("FAIL dec_bank_group: got %0h expected 5", bus.out_bank_group); end
    n_checks++; if (bus.out_bank !== 2'd3) begin n_fail++; $display("FAIL dec_bank: got %0h expected 3", bus.out_bank); end
    n_checks++; if (bus.out_row !== 16'hB7AB) begin n_fail++; $display("FAIL dec_row: got %0h expected b7ab", bus.out_row); end
    n_checks++; if (bus.out_late !== 1'b0) begin n_fail++; $display("FAIL dec_late: got %0b expected 0", bus.out_late); end
    n_checks++; if (bus.out_core !== 4'd5 || bus.out_op !== 2'd1 || bus.out_time !== 64'd0) begin n_fail++; $display("FAIL dec_meta: got core=%0d op=%0d time=%0d expected 5 1 0", bus.out_core, bus.out_op, bus.out_time); end
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL dec_count: got %0d expected 0", bus.count); end

    // Reserved op 3 passes through; cpu_cycle is 1 when it loads, so it is late.
    drive(4'd15, 64'd0, 2'd3, 34'h0);
    step();  // edge 3
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.count !== 5'd1) begin n_fail++; $display("FAIL op3_gap: got valid=%0b count=%0d expected 0 1", bus.out_valid, bus.count); end
    step();  // edge 4
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_op !== 2'd3 || bus.out_core !== 4'd15) begin n_fail++; $display("FAIL op3_out: got valid=%0b op=%0d core=%0d expected 1 3 15", bus.out_valid, bus.out_op, bus.out_core); end
    n_checks++; if (bus.out_late !== 1'b1 || bus.out_row !== 16'd0 || bus.out_column !== 10'd0) begin n_fail++; $display("FAIL op3_fields: got late=%0b row=%0h col=%0h expected 1 0 0", bus.out_late, bus.out_row, bus.out_column); end
    step();  // edge 5
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL op3_drain: got valid=%0b expected 0", bus.out_valid); end
  endtask

  task automatic test_time_gating();
    do_reset();
    bus.out_ready = 1'b1;
    drive(4'd1, 64'd10, OP_READ, {16'd1, 18'h0});
    step();  // edge 1
    drive(4'd2, 64'd5, OP_READ, {16'd2, 18'h0});
    step();  // edge 2
    bus.in_valid = 1'b0;
    n_checks++; if (bus.count !== 5'd2) begin n_fail++; $display("FAIL gate_count: got %0d expected 2", bus.count); end
    for (int k = 3; k <= 20; k++) begin
      step();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL gate_early_edge%0d: got valid=%0b expected 0", k, bus.out_valid); end
    end
    n_checks++; if (bus.cpu_cycle !== 64'd10 || bus.count !== 5'd2) begin n_fail++; $display("FAIL gate_at10: got cyc=%0d count=%0d expected 10 2", bus.cpu_cycle, bus.count); end
    step();  // edge 21
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_time !== 64'd10 || bus.out_core !== 4'd1) begin n_fail++; $display("FAIL gate_first: got valid=%0b time=%0d core=%0d expected 1 10 1", bus.out_valid, bus.out_time, bus.out_core); end
    n_checks++; if (bus.out_late !== 1'b0) begin n_fail++; $display("FAIL gate_first_late: got %0b expected 0", bus.out_late); end
    step();  // edge 22
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_time !== 64'd5 || bus.out_core !== 4'd2) begin n_fail++; $display("FAIL gate_second: got valid=%0b time=%0d core=%0d expected 1 5 2", bus.out_valid, bus.out_time, bus.out_core); end
    n_checks++; if (bus.out_late !== 1'b1) begin n_fail++; $display("FAIL gate_second_late: got %0b expected 1", bus.out_late); end
    step();  // edge 23
    n_checks++; if (bus.out_valid !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL gate_drain: got valid=%0b empty=%0b expected 0 1", bus.out_valid, bus.empty); end
  endtask

  task automatic test_full();
    int   got;
    logic first;
    logic push_now;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 64'd1000, OP_READ, {16'(i), 18'h0});
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d: got %0b expected 1", i, bus.in_ready); end
      step();
    end
    n_checks++; if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL full_flags: got count=%0d full=%0b empty=%0b expected 16 1 0", bus.count, bus.full, bus.empty); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %0b expected 0", bus.in_ready); end
    drive(4'd0, 64'd1000, OP_READ, {16'd16, 18'h0});
    repeat (3) step();
    n_checks++; if (bus.count !== 5'd16 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold: got count=%0d valid=%0b ready=%0b expected 16 0 0", bus.count, bus.out_valid, bus.in_ready); end

    got   = 0;
    first = 1'b1;
    for (int c = 0; c < 2200 && got < 17; c++) begin
      push_now = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        if (first) begin
          first = 1'b0;
          n_checks++; if (bus.count !== 5'd15 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_first_pop: got count=%0d ready=%0b expected 15 1", bus.count, bus.in_ready); end
          n_checks++; if (bus.cpu_cycle !== 64'd1000 || bus.out_late !== 1'b0) begin n_fail++; $display("FAIL full_first_time: got cyc=%0d late=%0b expected 1000 0", bus.cpu_cycle, bus.out_late); end
        end
        n_checks++; if (bus.out_row !== 16'(got)) begin n_fail++; $display("FAIL full_order: got row=%0d expected %0d", bus.out_row, got); end
        got++;
      end
      step();
      if (push_now) bus.in_valid = 1'b0;
    end
    n_checks++; if (got !== 17) begin n_fail++; $display("FAIL full_drain_count: got %0d expected 17", got); end
    n_checks++; if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got empty=%0b valid=%0b expected 1 0", bus.empty, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(4'(i), 64'd0, OP_WRITE, {16'(i), 18'h0});
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_row !== 16'd1 || bus.count !== 5'd2) begin n_fail++; $display("FAIL bp_start: got valid=%0b row=%0d count=%0d expected 1 1 2", bus.out_valid, bus.out_row, bus.count); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_row !== 16'd1 || bus.out_core !== 4'd1 || bus.out_op !== 2'd1 ||
          bus.out_time !== 64'd0 || bus.out_late !== 1'b0 || bus.out_column !== 10'd0 || bus.count !== 5'd2) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got valid=%0b row=%0d core=%0d op=%0d late=%0b count=%0d expected 1 1 1 1 0 2",
                 k, bus.out_valid, bus.out_row, bus.out_core, bus.out_op, bus.out_late, bus.count);
      end
    end
    bus.out_ready = 1'b1;
    step();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_row !== 16'd2 || bus.count !== 5'd1) begin n_fail++; $display("FAIL bp_rel1: got valid=%0b row=%0d count=%0d expected 1 2 1", bus.out_valid, bus.out_row, bus.count); end
    step();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_row !== 16'd3 || bus.count !== 5'd0) begin n_fail++; $display("FAIL bp_rel2: got valid=%0b row=%0d count=%0d expected 1 3 0", bus.out_valid, bus.out_row, bus.count); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rel3: got valid=%0b expected 0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    int               got;
    logic             push_now;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] exp_row;
    do_reset();
    exp_q.delete();
    got = 0;
    bus4.out_ready = 1'b1;
    for (int k = 0; k < 48; k++) begin
      row = 16'(k * 3 + 7);
      if (k < 41) begin
        bus4.in_valid = 1'b1;
        bus4.in_core  = 4'(k);
        bus4.in_time  = 64'd0;
        bus4.in_op    = 2'(k % 3);
        bus4.in_addr  = {row, 18'h0};
      end else begin
        bus4.in_valid = 1'b0;
      end
      push_now = bus4.in_valid && bus4.in_ready;
      if (k >= 2 && k <= 42) begin
        n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_stream_%0d: got valid=%0b expected 1", k, bus4.out_valid); end
      end
      if (bus4.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wrap_extra: got row=%0d expected none", bus4.out_row);
        end else begin
          exp_row = exp_q.pop_front();
          n_checks++; if (bus4.out_row !== exp_row) begin n_fail++; $display("FAIL wrap_order: got row=%0d expected %0d", bus4.out_row, exp_row); end
          got++;
        end
      end
      if (push_now) exp_q.push_back(row);
      step();
      if (k <= 40) begin
        n_checks++; if (bus4.count !== 3'd1) begin n_fail++; $display("FAIL wrap_count_%0d: got %0d expected 1", k, bus4.count); end
      end
    end
    n_checks++; if (got !== 41 || exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_total: got %0d left=%0d expected 41 0", got, exp_q.size()); end
    n_checks++; if (bus4.empty !== 1'b1 || bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drained: got empty=%0b valid=%0b expected 1 0", bus4.empty, bus4.out_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_decode();
    test_time_gating();
    test_full();
    test_backpressure();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
